// File: rtl/mem_access_ctrl_if.sv
// Request/response bundle between the MEM stage (master) and mem_access_ctrl (slave).
interface mem_access_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  op;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        resp_valid;
   logic [31:0] rdata;
   logic        addr_err;
   logic [31:0] err_addr;

   modport master (
      output req_valid, op, addr, wdata,
      input  req_ready, resp_valid, rdata, addr_err, err_addr
   );

   modport slave (
      input  req_valid, op, addr, wdata,
      output req_ready, resp_valid, rdata, addr_err, err_addr
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store controller driving a big-endian byte-lane RAM.
// Misaligned-access trapping is built in only when MEM_ALIGN_CHECK_EN is defined.
module mem_access_ctrl (
   input  logic              clk,
   input  logic              rst_n,
   mem_access_ctrl_if.slave  bus,
   output logic              ram_en,
   output logic              ram_we,
   output logic [31:0]       ram_addr,
   output logic [3:0]        ram_sel,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   localparam logic [3:0] OP_LB  = 4'd0;
   localparam logic [3:0] OP_LBU = 4'd1;
   localparam logic [3:0] OP_LH  = 4'd2;
   localparam logic [3:0] OP_LHU = 4'd3;
   localparam logic [3:0] OP_LW  = 4'd4;
   localparam logic [3:0] OP_SB  = 4'd5;
   localparam logic [3:0] OP_SH  = 4'd6;
   localparam logic [3:0] OP_SW  = 4'd7;

   logic [1:0]  state;
   logic [1:0]  state_next;
   logic        ready_q;
   logic [3:0]  op_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        addr_err_q;
   logic        accept;
   logic        misaligned;
   logic        resp;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [31:0] load_data;
   logic [3:0]  sel;

   // ready is registered so it stays low until the first edge after reset release
   assign accept = bus.req_valid && ready_q;

`ifdef MEM_ALIGN_CHECK_EN
   logic [31:0] err_addr_q;

   always_comb begin
      misaligned = 1'b0;
      case (bus.op)
         OP_LH, OP_LHU, OP_SH: misaligned = bus.addr[0];
         OP_LW, OP_SW:         misaligned = |bus.addr[1:0];
         default:              misaligned = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_addr_q <= '0;
      else if (accept && misaligned)
         err_addr_q <= bus.addr;
   end

   assign bus.err_addr = err_addr_q;
`else
   assign misaligned   = 1'b0;
   assign bus.err_addr = '0;
`endif

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = misaligned ? RESP : ACCESS;
         ACCESS:  state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ready_q    <= 1'b0;
         op_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         addr_err_q <= 1'b0;
      end else begin
         state   <= state_next;
         ready_q <= (state_next == IDLE);
         if (accept) begin
            op_q       <= bus.op;
            addr_q     <= bus.addr;
            wdata_q    <= bus.wdata;
            rdata_q    <= '0;
            addr_err_q <= misaligned;
         end
         if (state == ACCESS)
            rdata_q <= load_data;
      end
   end

   // big-endian lanes: byte offset 0 lives in bits 31:24
   always_comb begin
      case (addr_q[1:0])
         2'd0:    lane_byte = ram_rdata[31:24];
         2'd1:    lane_byte = ram_rdata[23:16];
         2'd2:    lane_byte = ram_rdata[15:8];
         default: lane_byte = ram_rdata[7:0];
      endcase
      lane_half = addr_q[1] ? ram_rdata[15:0] : ram_rdata[31:16];
   end

   always_comb begin
      load_data = '0;
      case (op_q)
         OP_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
         OP_LBU:  load_data = {24'd0, lane_byte};
         OP_LH:   load_data = {{16{lane_half[15]}}, lane_half};
         OP_LHU:  load_data = {16'd0, lane_half};
         OP_LW:   load_data = ram_rdata;
         default: load_data = '0;
      endcase
   end

   always_comb begin
      sel = 4'b0000;
      case (op_q)
         OP_LB, OP_LBU, OP_SB: sel = 4'b1000 >> addr_q[1:0];
         OP_LH, OP_LHU, OP_SH: sel = addr_q[1] ? 4'b0011 : 4'b1100;
         OP_LW, OP_SW:         sel = 4'b1111;
         default:              sel = 4'b0000;
      endcase
   end

   always_comb begin
      ram_wdata = wdata_q;
      case (op_q)
         OP_SB:   ram_wdata = {4{wdata_q[7:0]}};
         OP_SH:   ram_wdata = {2{wdata_q[15:0]}};
         default: ram_wdata = wdata_q;
      endcase
   end

   // illegal ops (bit 3 set) pass through ACCESS without touching the RAM
   assign ram_en   = (state == ACCESS) && !op_q[3];
   assign ram_we   = ram_en && (op_q >= OP_SB);
   assign ram_sel  = ram_en ? sel : 4'b0000;
   assign ram_addr = addr_q;

   assign resp           = (state == RESP);
   assign bus.req_ready  = ready_q;
   assign bus.resp_valid = resp;
   assign bus.rdata      = resp ? rdata_q : '0;
   assign bus.addr_err   = resp && addr_err_q;
endmodule
